// File: rtl/xadc_axi_test_if.sv
// xadc_axi_test_if: status outputs of the emulated XADC AXI-lite loopback
interface xadc_axi_test_if;
    logic       eoc_0;
    logic [1:0] mst_exec_state_0;
    logic [2:0] val;
    modport master (output eoc_0, mst_exec_state_0, val);
    modport slave  (input  eoc_0, mst_exec_state_0, val);
endinterface

// File: rtl/xadc_axi_test.sv
// xadc_axi_test: emulated ADC samples written then read back through an internal AXI-lite slave
// XADC_AXI_COMPARE_EN adds a COMPARE state so val only updates when the readback matches.
module xadc_axi_test #(
    parameter int CONV_CYCLES = 26,
    parameter int SAMPLE_STEP = 64
) (
    input  logic            clk,
    input  logic            rstn,
    xadc_axi_test_if.master mon
);
`ifdef XADC_AXI_COMPARE_EN
    typedef enum logic [1:0] {IDLE = 2'b00, WRITE = 2'b01, READ = 2'b10, COMPARE = 2'b11} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'b00, WRITE = 2'b01, READ = 2'b10} state_t;
`endif
    localparam logic [1:0] OKAY = 2'b00;
    state_t      state, state_nxt;
    logic [9:0]  timer;
    logic [11:0] sample, sample_nxt, wdata, slv_reg, rdata;
    logic [2:0]  val;
    logic [1:0]  bresp;
    logic        eoc, aw_done, ar_done;
    logic        awvalid, wvalid, awready, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic        aw_hs, b_hs, ar_hs, r_hs;

    assign eoc        = !rstn && timer == 10'(CONV_CYCLES - 1);
    assign sample_nxt = sample + 12'(SAMPLE_STEP);
    always_ff @(posedge clk) begin
        if (rstn) begin
            timer  <= '0;
            sample <= '0;
        end else begin
            timer <= eoc ? '0 : timer + 10'd1;
            if (eoc) sample <= sample_nxt;
        end
    end

    assign awvalid = state == WRITE && !aw_done;
    assign wvalid  = awvalid;
    assign bready  = state == WRITE;
    assign arvalid = state == READ && !ar_done;
    assign rready  = state == READ;
    assign aw_hs   = awvalid && awready && wvalid && wready;
    assign b_hs    = bvalid && bready;
    assign ar_hs   = arvalid && arready;
    assign r_hs    = rvalid && rready;
    assign bresp   = OKAY;

    // single-register slave: each ready is a one-cycle pulse following the request
    always_ff @(posedge clk) begin
        if (rstn) begin
            {awready, wready, bvalid, arready, rvalid} <= '0;
            slv_reg <= '0;
            rdata   <= '0;
        end else begin
            awready <= awvalid && wvalid && !awready;
            wready  <= awvalid && wvalid && !awready;
            bvalid  <= aw_hs ? 1'b1 : b_hs ? 1'b0 : bvalid;
            arready <= arvalid && !arready;
            rvalid  <= ar_hs ? 1'b1 : r_hs ? 1'b0 : rvalid;
            if (aw_hs) slv_reg <= wdata;
            if (ar_hs) rdata <= slv_reg;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = eoc ? WRITE : IDLE;
            WRITE:   state_nxt = (b_hs && bresp == OKAY) ? READ : WRITE;
`ifdef XADC_AXI_COMPARE_EN
            READ:    state_nxt = r_hs ? COMPARE : READ;
            COMPARE: state_nxt = IDLE;
`else
            READ:    state_nxt = r_hs ? IDLE : READ;
`endif
            default: state_nxt = IDLE;
        endcase
    end

`ifdef XADC_AXI_COMPARE_EN
    logic [11:0] rback;
    always_ff @(posedge clk) begin
        if (rstn) begin
            rback <= '0;
            val   <= '0;
        end else begin
            if (r_hs) rback <= rdata;
            if (state == COMPARE && rback == wdata) val <= rback[11:9];
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^rdata[8:0];
    always_ff @(posedge clk) begin
        if (rstn) val <= '0;
        else if (r_hs) val <= rdata[11:9];
    end
`endif

    always_ff @(posedge clk) begin
        if (rstn) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            ar_done <= 1'b0;
            wdata   <= '0;
        end else begin
            state   <= state_nxt;
            aw_done <= state == WRITE && (aw_done || aw_hs);
            ar_done <= state == READ && (ar_done || ar_hs);
            if (state == IDLE && eoc) wdata <= sample_nxt;
        end
    end

    assign mon.eoc_0            = eoc;
    assign mon.mst_exec_state_0 = state;
    assign mon.val              = val;
endmodule

// File: tb/tb_xadc_axi_test.sv
// tb_xadc_axi_test: scoreboard bench; expected conversions queued by stimulus, checked by a monitor
module tb_xadc_axi_test;
    localparam int C = 26;
    localparam int STEP = 64;
`ifdef XADC_AXI_COMPARE_EN
    localparam int LEN = 7;
    localparam logic [15:0] SEQ = 16'b0001010110101011;
`else
    localparam int LEN = 6;
    localparam logic [15:0] SEQ = 16'b0000010101101010;
`endif

    typedef struct {int n; int v; bit abort;} item_t;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    xadc_axi_test_if bus();
    xadc_axi_test #(.CONV_CYCLES(C), .SAMPLE_STEP(STEP)) dut (.clk(clk), .rstn(rstn), .mon(bus));

    item_t q[$];
    int checks = 0;
    int errors = 0;
    bit busy = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference: val after the k-th conversion since reset is bits [11:9] of k*STEP mod 4096
    function automatic int val_of(int k);
        return ((k * STEP) % 4096) >> 9;
    endfunction

    // monitor: n counts cycles since reset release (1 = first cycle out of reset)
    int n = 0;
    int rcnt = 0;
    int len = 0;
    int last_val = 0;
    logic [15:0] seq = '0;
    item_t cur;
    always @(negedge clk) begin
        if (rstn) begin
            n = 0;
            rcnt++;
            if (busy) begin
                busy = 0;
                chk("abort_expected", int'(cur.abort), 1);
            end
            if (rcnt == 2) begin
                chk("rst_eoc", int'(bus.eoc_0), 0);
                chk("rst_state", int'(bus.mst_exec_state_0), 0);
                chk("rst_val", int'(bus.val), 0);
                last_val = 0;
            end
        end else begin
            rcnt = 0;
            n++;
            if (busy) begin
                if (bus.mst_exec_state_0 == 2'b00) begin
                    busy = 0;
                    chk("state_seq", int'(seq), int'(SEQ));
                    chk("state_len", len, LEN);
                    chk("val", int'(bus.val), cur.v);
                    last_val = cur.v;
                end else begin
                    seq = {seq[13:0], bus.mst_exec_state_0};
                    len++;
                end
            end
            if (bus.eoc_0) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_eoc actual=1 expected=0 at cycle %0d", n);
                end else begin
                    cur = q.pop_front();
                    chk("eoc_time", n, cur.n);
                    chk("val_hold", int'(bus.val), last_val);
                    busy = 1;
                    seq = '0;
                    len = 0;
                end
            end
        end
    end

    // queue conv full transactions, optionally abort the next one inside WRITE; ends in reset
    task automatic run(int conv, bit abort);
        for (int k = 1; k <= conv; k++) q.push_back('{C * k, val_of(k), 1'b0});
        if (abort) begin
            q.push_back('{C * (conv + 1), 0, 1'b1});
            repeat (C * (conv + 1) + int'($urandom_range(0, 2))) @(posedge clk);
        end else begin
            repeat (C * conv + 8) @(posedge clk);
        end
        #1 rstn = 1'b1;
    endtask

    task automatic release_after(int r);
        repeat (r) @(posedge clk);
        #1 rstn = 1'b0;
    endtask

    initial begin
        rstn = 1'b1;
        release_after(3);
        run(66, 1'b1);
        release_after($urandom_range(2, 5));
        run($urandom_range(1, 20), 1'b1);
        release_after($urandom_range(2, 5));
        run($urandom_range(1, 30), 1'b0);
        release_after($urandom_range(2, 5));
        run(16, 1'b0);
        repeat (4) @(posedge clk);
        chk("queue_empty", q.size(), 0);
        chk("monitor_idle", int'(busy), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (20000) @(posedge clk);
        checks++;
        errors++;
        $display("FAIL watchdog actual=timeout required=completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
